uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// rtl/uart_core.sv - 16x-oversampled UART with TX/RX FIFOs and sticky RX errors.
// Optional feature macro UART_LOOPBACK_EN: when defined, loopback=1 routes tx into rx and parks the tx_out pin high.
module uart_core #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [15:0]                   baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic                          loopback,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_wr_en,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_busy,
    output logic                          tx_out,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_rd_en,
    output logic                          rx_full,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_frame_error,
    output logic                          rx_parity_error,
    output logic                          rx_overflow,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [15:0] r_tick_cnt;
    logic        w_tick;
    assign w_tick = (r_tick_cnt >= baud_div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_tx_wp, r_tx_rp;
    logic [LW-1:0]        r_tx_level;
    logic                 w_tx_push, w_tx_pop;

    assign tx_empty  = (r_tx_level == '0);
    assign tx_full   = (r_tx_level == LW'(FIFO_DEPTH));
    assign tx_level  = r_tx_level;
    assign w_tx_push = tx_wr_en && (!tx_full || w_tx_pop);

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            r_tx_level <= r_tx_level + LW'(w_tx_push) - LW'(w_tx_pop);
        end
    end

    state_t               r_tx_state;
    logic [4:0]           r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx_par_en, r_tx_two_stop, r_tx_out;
    logic                 w_tx_bit_end, w_tx_stop_end;

    assign w_tx_bit_end  = w_tick && (r_tx_cnt[3:0] == 4'd15);
    assign w_tx_stop_end = w_tick && (r_tx_cnt == (r_tx_two_stop ? 5'd31 : 5'd15));
    // A queued word starts straight out of the last stop tick so back-to-back frames have no gap.
    assign w_tx_pop = w_tick && !tx_empty &&
                      ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_stop_end));
    assign tx_busy  = (r_tx_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state    <= S_IDLE;
            r_tx_cnt      <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx_par_en   <= 1'b0;
            r_tx_two_stop <= 1'b0;
            r_tx_out      <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_state    <= S_START;
            r_tx_cnt      <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= r_tx_mem[r_tx_rp];
            r_tx_par      <= (^r_tx_mem[r_tx_rp]) ^ parity_odd;
            r_tx_par_en   <= parity_en;
            r_tx_two_stop <= two_stop;
            r_tx_out      <= 1'b0;
        end else if (w_tick) begin
            r_tx_cnt <= r_tx_cnt + 5'd1;
            case (r_tx_state)
                S_START: if (w_tx_bit_end) begin
                    r_tx_state <= S_DATA;
                    r_tx_cnt   <= '0;
                    r_tx_out   <= r_tx_shift[0];
                end
                S_DATA: if (w_tx_bit_end) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                        r_tx_state <= r_tx_par_en ? S_PARITY : S_STOP;
                        r_tx_out   <= r_tx_par_en ? r_tx_par : 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_out   <= r_tx_shift[1];
                    end
                end
                S_PARITY: if (w_tx_bit_end) begin
                    r_tx_state <= S_STOP;
                    r_tx_cnt   <= '0;
                    r_tx_out   <= 1'b1;
                end
                S_STOP: if (w_tx_stop_end) begin
                    r_tx_state <= S_IDLE;
                    r_tx_cnt   <= '0;
                end
                default: r_tx_cnt <= '0;
            endcase
        end
    end

    logic w_rx_src;
`ifdef UART_LOOPBACK_EN
    assign w_rx_src = loopback ? r_tx_out : rx_in;
    assign tx_out   = loopback ? 1'b1 : r_tx_out;
`else
    logic w_unused_loopback;
    assign w_unused_loopback = loopback;
    assign w_rx_src = rx_in;
    assign tx_out   = r_tx_out;
`endif

    logic r_rx_sync1, r_rx_sync2, r_rx_prev;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= w_rx_src;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    state_t               r_rx_state;
    logic [3:0]           r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_en, r_rx_par_odd;
    logic                 w_rx_mid, w_rx_push, w_rx_pop, w_rx_wr;

    // Start is re-checked half a bit in; every later sample lands one full bit after the previous one.
    assign w_rx_mid  = w_tick && (r_rx_cnt == ((r_rx_state == S_START) ? 4'd7 : 4'd15));
    assign w_rx_push = (r_rx_state == S_STOP) && w_rx_mid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else if (r_rx_state == S_IDLE) begin
            if (r_rx_prev && !r_rx_sync2) begin
                r_rx_state   <= S_START;
                r_rx_cnt     <= '0;
                r_rx_bit     <= '0;
                r_rx_par_en  <= parity_en;
                r_rx_par_odd <= parity_odd;
            end
        end else if (w_tick) begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (w_rx_mid) begin
                r_rx_cnt <= '0;
                case (r_rx_state)
                    S_START: r_rx_state <= r_rx_sync2 ? S_IDLE : S_DATA;
                    S_DATA: begin
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'(DATA_BITS - 1))
                            r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
                    end
                    S_PARITY: r_rx_state <= S_STOP;
                    default:  r_rx_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rx_wp, r_rx_rp;
    logic [LW-1:0]        r_rx_level;
    logic                 r_fe, r_pe, r_ov;

    assign rx_empty = (r_rx_level == '0);
    assign rx_full  = (r_rx_level == LW'(FIFO_DEPTH));
    assign rx_level = r_rx_level;
    assign rx_data  = rx_empty ? '0 : r_rx_mem[r_rx_rp];
    assign w_rx_pop = rx_rd_en && !rx_empty;
    assign w_rx_wr  = w_rx_push && (!rx_full || w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_level <= '0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_ov       <= 1'b0;
        end else begin
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
            r_rx_level <= r_rx_level + LW'(w_rx_wr) - LW'(w_rx_pop);
            r_fe <= (w_rx_push && !r_rx_sync2) || (r_fe && !err_clr);
            r_pe <= ((r_rx_state == S_PARITY) && w_rx_mid &&
                     (r_rx_sync2 != ((^r_rx_shift) ^ r_rx_par_odd))) || (r_pe && !err_clr);
            r_ov <= (w_rx_push && !w_rx_wr) || (r_ov && !err_clr);
        end
    end

    assign rx_frame_error  = r_fe;
    assign rx_parity_error = r_pe;
    assign rx_overflow     = r_ov;
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core (FIFO_DEPTH=4); covers UART_LOOPBACK_EN when defined.
`timescale 1ns/1ps
module tb_uart_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0, loopback = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_wr_en = 1'b0;
    logic        tx_full, tx_empty, tx_busy, tx_out;
    logic [2:0]  tx_level, rx_level;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_rd_en = 1'b0;
    logic        rx_full, rx_empty, rx_frame_error, rx_parity_error, rx_overflow;
    logic        err_clr = 1'b0;

    logic rx_drv = 1'b1, ext_loop = 1'b0;
    assign rx_in = ext_loop ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .two_stop(two_stop), .loopback(loopback),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_level(tx_level), .tx_busy(tx_busy), .tx_out(tx_out), .rx_in(rx_in),
        .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_full(rx_full), .rx_empty(rx_empty),
        .rx_level(rx_level), .rx_frame_error(rx_frame_error),
        .rx_parity_error(rx_parity_error), .rx_overflow(rx_overflow), .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx_q[$];
    logic [1:0] tx_q[$];
    bit auto_rd = 1'b0;
    bit hold_hi = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always begin : rx_monitor
        logic [7:0] e;
        @(posedge clk);
        #2;
        rx_rd_en = 1'b0;
        if (auto_rd && reset_n && !rx_empty) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got word 0x%0h, none expected", rx_data);
            end else begin
                e = rx_q.pop_front();
                check("rx_data", rx_data, e);
            end
            rx_rd_en = 1'b1;
        end
    end

    always begin : tx_monitor
        logic [1:0] e;
        @(posedge clk);
        #2;
        if (tx_q.size() > 0) begin
            e = tx_q.pop_front();
            check("tx_out_wave", tx_out, e[0]);
            check("tx_busy_wave", tx_busy, e[1]);
        end
        if (hold_hi) check("tx_out_held_high", tx_out, 1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_wr_en = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_drv = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic wait_q(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rx_q.size() != 0 || tx_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d rx / %0d tx entries pending after %0d cycles",
                     name, rx_q.size(), tx_q.size(), budget);
            rx_q.delete();
            tx_q.delete();
        end
        idle(3);
    endtask

    task automatic check_errs(input string name, input logic fe, input logic pe, input logic ov);
        check({name, "_frame_err"}, rx_frame_error, fe);
        check({name, "_parity_err"}, rx_parity_error, pe);
        check({name, "_overflow"}, rx_overflow, ov);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        idle(2);
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_full", rx_full, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_data", rx_data, 0);
        check_errs("rst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        auto_rd = 1'b1;
        idle(3);

        // 0xA5, no parity, one stop: 16 low, bits 1,0,1,0,0,1,0,1, 16 high, then idle.
        tx_write(a5);
        repeat (16) tx_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) repeat (16) tx_q.push_back({1'b1, a5[i]});
        repeat (16) tx_q.push_back(2'b11);
        tx_q.push_back(2'b01);
        wait_q("tx_a5", 400);
        check("tx_a5_empty", tx_empty, 1);

        // Short low glitch must be rejected, then a real frame must still be received.
        @(negedge clk);
        rx_drv = 1'b0;
        idle(5);
        rx_drv = 1'b1;
        idle(40);
        check("glitch_rx_level", rx_level, 0);
        check_errs("glitch", 0, 0, 0);
        rx_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        wait_q("rx_81", 200);
        check_errs("rx_81", 0, 0, 0);

        // Bad stop bit: word kept, frame error sticky until cleared.
        rx_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        wait_q("rx_55", 200);
        check_errs("stop0", 1, 0, 0);
        idle(20);
        check("stop0_sticky", rx_frame_error, 1);
        pulse_err_clr();
        check_errs("stop0_clr", 0, 0, 0);

        // Even parity expected 0 for 0x3C; send 1.
        parity_en = 1'b1;
        parity_odd = 1'b0;
        rx_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_q("rx_badpar", 200);
        check_errs("badpar", 0, 1, 0);
        pulse_err_clr();
        check_errs("badpar_clr", 0, 0, 0);

        // Loopback with odd parity: internal when the feature is built in, external wire otherwise.
        parity_odd = 1'b1;
        loopback = 1'b1;
`ifdef UART_LOOPBACK_EN
        hold_hi = 1'b1;
`else
        ext_loop = 1'b1;
`endif
        rx_q.push_back(8'h3C);
        rx_q.push_back(8'hFF);
        tx_write(8'h3C);
        tx_write(8'hFF);
        wait_q("loopback", 800);
        idle(20);
        check("loop_tx_idle", tx_busy, 0);
        check_errs("loop", 0, 0, 0);
        hold_hi = 1'b0;
        ext_loop = 1'b0;
        loopback = 1'b0;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        idle(5);

        // Five frames with no reads into a 4-deep FIFO.
        auto_rd = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) rx_q.push_back(8'(i * 17));
            send_frame(8'(i * 17), 1'b0, 1'b0, 1'b1);
        end
        check("ovf_level", rx_level, 4);
        check("ovf_full", rx_full, 1);
        check_errs("ovf", 0, 0, 1);
        auto_rd = 1'b1;
        wait_q("ovf_drain", 100);
        check("ovf_drained", rx_empty, 1);
        pulse_err_clr();
        check_errs("ovf_clr", 0, 0, 0);

        // TX FIFO fills with no tick; the fifth write is dropped.
        baud_div = 16'hFFFF;
        @(negedge clk);
        tx_data = 8'h00;
        tx_wr_en = 1'b1;
        idle(5);
        tx_wr_en = 1'b0;
        check("txfull_level", tx_level, 4);
        check("txfull_flag", tx_full, 1);

        // Reset lands in data bit 1 of an all-zero frame.
        baud_div = 16'd0;
        idle(40);
        check("mid_tx_busy", tx_busy, 1);
        check("mid_tx_out", tx_out, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tx_out", tx_out, 1);
        check("arst_tx_empty", tx_empty, 1);
        check("arst_tx_busy", tx_busy, 0);
        check("arst_tx_level", tx_level, 0);
        check("arst_rx_data", rx_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        hold_hi = 1'b1;
        idle(300);
        hold_hi = 1'b0;
        check("post_rst_tx_empty", tx_empty, 1);
        check("post_rst_tx_busy", tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
